// File: rtl/palette_fade_ctrl.sv
// Writable 16-entry RGB palette with vblank-serialised writes and a frame-locked
// brightness fade sequencer; lookups are scaled by the current level with 1-cycle latency.
module palette_fade_ctrl #(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned STEP_FRAMES = 2,
  parameter int unsigned MAX_LEVEL   = 16
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic [$clog2(NUM_ENTRIES)-1:0] index,
  input  logic                           pix_valid,
  output logic [3:0]                     red,
  output logic [3:0]                     green,
  output logic [3:0]                     blue,
  output logic                           rgb_valid,
  input  logic                           vblank,
  input  logic                           frame_start,
  input  logic                           wr_req,
  input  logic [$clog2(NUM_ENTRIES)-1:0] wr_idx,
  input  logic [11:0]                    wr_rgb,
  output logic                           wr_ack,
  input  logic                           fade_start,
  input  logic                           fade_dir,
  output logic                           fade_busy,
  output logic                           fade_done,
  output logic [4:0]                     level
);

  localparam logic [4:0] LvlMax  = 5'(MAX_LEVEL);
  localparam logic [3:0] LastCnt = 4'(STEP_FRAMES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StStep} state_e;

  function automatic logic [11:0] default_rgb(input int i);
    case (i)
      0:       return 12'h000;
      1:       return 12'h763;
      2:       return 12'h220;
      3:       return 12'h0BE;
      4:       return 12'h171;
      5:       return 12'h866;
      6:       return 12'h654;
      7:       return 12'hD10;
      8:       return 12'h220;
      9:       return 12'h311;
      10:      return 12'h477;
      11:      return 12'h652;
      12:      return 12'h232;
      13:      return 12'h433;
      14:      return 12'h8DE;
      15:      return 12'h2C1;
      default: return 12'h000;
    endcase
  endfunction

  // 4x5-bit product; keep bits [7:4] so level 16 passes the colour unchanged.
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] l);
    logic [8:0] p;
    p = {5'd0, c} * {4'd0, l};
    return p[7:4];
  endfunction

  logic [11:0] pal_q [NUM_ENTRIES];
  logic [11:0] entry;
  logic        wr_commit;

  state_e      state_q;
  logic        dir_q;
  logic [3:0]  cnt_q;
  logic [4:0]  lvl_next;
  logic        at_target;

  assign entry     = pal_q[index];
  assign wr_commit = wr_req & vblank & ~wr_ack;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) pal_q[i] <= default_rgb(i);
      wr_ack    <= 1'b0;
      rgb_valid <= 1'b0;
      red       <= 4'd0;
      green     <= 4'd0;
      blue      <= 4'd0;
    end else begin
      if (wr_commit) pal_q[wr_idx] <= wr_rgb;
      wr_ack    <= wr_commit;
      rgb_valid <= pix_valid;
      // Reads the pre-write entry and pre-step level sampled at this same edge.
      if (pix_valid) begin
        red   <= scale(entry[11:8], level);
        green <= scale(entry[7:4], level);
        blue  <= scale(entry[3:0], level);
      end else begin
        red   <= 4'd0;
        green <= 4'd0;
        blue  <= 4'd0;
      end
    end
  end

  always_comb begin
    lvl_next = level;
    if (dir_q) begin
      if (level != LvlMax) lvl_next = level + 5'd1;
    end else begin
      if (level != 5'd0) lvl_next = level - 5'd1;
    end
    at_target = dir_q ? (lvl_next == LvlMax) : (lvl_next == 5'd0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      dir_q     <= 1'b0;
      cnt_q     <= 4'd0;
      level     <= LvlMax;
      fade_busy <= 1'b0;
      fade_done <= 1'b0;
    end else begin
      fade_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (fade_start) begin
            dir_q <= fade_dir;
            cnt_q <= 4'd0;
            if ((fade_dir && level == LvlMax) || (!fade_dir && level == 5'd0)) begin
              fade_done <= 1'b1;
            end else begin
              state_q   <= StWait;
              fade_busy <= 1'b1;
            end
          end
        end
        StWait: begin
          if (frame_start) begin
            if (cnt_q == LastCnt) state_q <= StStep;
            else                  cnt_q   <= cnt_q + 4'd1;
          end
        end
        StStep: begin
          level <= lvl_next;
          if (at_target) begin
            state_q   <= StIdle;
            fade_busy <= 1'b0;
            fade_done <= 1'b1;
          end else begin
            cnt_q   <= 4'd0;
            state_q <= StWait;
          end
        end
        default: begin
          state_q   <= StIdle;
          fade_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// Randomised self-checking bench for palette_fade_ctrl against an arithmetic palette/level model.
module tb_palette_fade_ctrl;

  localparam int STEP_FRAMES = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [3:0]  index;
  logic        pix_valid;
  logic [3:0]  red, green, blue;
  logic        rgb_valid;
  logic        vblank, frame_start, wr_req;
  logic [3:0]  wr_idx;
  logic [11:0] wr_rgb;
  logic        wr_ack;
  logic        fade_start, fade_dir, fade_busy, fade_done;
  logic [4:0]  level;

  palette_fade_ctrl #(
    .NUM_ENTRIES(16),
    .STEP_FRAMES(STEP_FRAMES),
    .MAX_LEVEL  (16)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .index      (index),
    .pix_valid  (pix_valid),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .rgb_valid  (rgb_valid),
    .vblank     (vblank),
    .frame_start(frame_start),
    .wr_req     (wr_req),
    .wr_idx     (wr_idx),
    .wr_rgb     (wr_rgb),
    .wr_ack     (wr_ack),
    .fade_start (fade_start),
    .fade_dir   (fade_dir),
    .fade_busy  (fade_busy),
    .fade_done  (fade_done),
    .level      (level)
  );

  always #5 Clk = ~Clk;

  wire [12:0] pix = {rgb_valid, red, green, blue};

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;

  int pal_def [16] = '{12'h000, 12'h763, 12'h220, 12'h0BE, 12'h171, 12'h866, 12'h654, 12'hD10,
                       12'h220, 12'h311, 12'h477, 12'h652, 12'h232, 12'h433, 12'h8DE, 12'h2C1};
  int pal_m [16];
  int level_m;

  always @(negedge Clk) if (fade_done === 1'b1) done_seen++;

  // Expected {valid, r, g, b} one cycle after a lookup, from the model palette and level.
  function automatic logic [12:0] exp_pix(input int v, input int idx);
    logic [3:0] r, g, b;
    if (v == 0) return 13'd0;
    r = 4'((((pal_m[idx] >> 8) & 15) * level_m) >> 4);
    g = 4'((((pal_m[idx] >> 4) & 15) * level_m) >> 4);
    b = 4'(((pal_m[idx] & 15) * level_m) >> 4);
    return {1'b1, r, g, b};
  endfunction

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1; index = '0; pix_valid = 1'b1; vblank = 1'b1; frame_start = 1'b0;
    wr_req = 1'b1; wr_idx = 4'd7; wr_rgb = 12'hABC; fade_start = 1'b0; fade_dir = 1'b0;
    tick();
    tick();
    n_tests++;
    if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b want=0", wr_ack); end
    n_tests++;
    if (pix !== 13'd0) begin n_fail++; $display("FAIL reset_pix got=%h want=0", pix); end
    n_tests++;
    if ({level, fade_busy, fade_done} !== {5'd16, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_fade got=%0d/%b/%b want=16/0/0", level, fade_busy, fade_done);
    end
    Reset = 1'b0; wr_req = 1'b0; vblank = 1'b0; pix_valid = 1'b0;
    foreach (pal_m[i]) pal_m[i] = pal_def[i];
    level_m = 16;
    tick();
  endtask

  task automatic test_lookup();
    int v, idx;
    logic [12:0] e;
    pix_valid = 1'b1; index = 4'd3;
    tick();
    n_tests++;
    if (pix !== 13'h10BE) begin n_fail++; $display("FAIL lookup_idx3 got=%h want=10be", pix); end
    for (int k = 0; k < 30; k++) begin
      v = $urandom_range(0, 1); idx = $urandom_range(0, 15);
      pix_valid = v[0]; index = idx[3:0]; e = exp_pix(v, idx);
      tick();
      n_tests++;
      if (pix !== e) begin n_fail++; $display("FAIL lookup_rand idx=%0d got=%h want=%h", idx, pix, e); end
    end
    pix_valid = 1'b0;
    tick();
  endtask

  task automatic test_write_stall();
    int acks;
    acks = 0;
    wr_req = 1'b1; wr_idx = 4'd7; wr_rgb = 12'hFFF; vblank = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (wr_ack !== 1'b0) acks++;
    end
    n_tests++;
    if (acks != 0) begin n_fail++; $display("FAIL stall_no_ack got=%0d acks want=0", acks); end
    vblank = 1'b1;
    tick();
    n_tests++;
    if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL stall_ack got=%b want=1", wr_ack); end
    pal_m[7] = 12'hFFF;
    wr_req = 1'b0;
    tick();
    n_tests++;
    if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL stall_ack_pulse got=%b want=0", wr_ack); end
    vblank = 1'b0; pix_valid = 1'b1; index = 4'd7;
    tick();
    n_tests++;
    if (pix !== 13'h1FFF) begin n_fail++; $display("FAIL stall_readback got=%h want=1fff", pix); end
    pix_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int v1, v2, vb, idx, val, got;
    logic [12:0] e;
    v1 = $urandom_range(0, 4095); v2 = $urandom_range(0, 4095);
    vblank = 1'b1; wr_req = 1'b1; wr_idx = 4'd1; wr_rgb = v1[11:0];
    pix_valid = 1'b1; index = 4'd1;
    tick();
    n_tests++;
    if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack1 got=%b want=1", wr_ack); end
    n_tests++;
    if (pix !== 13'h1763) begin n_fail++; $display("FAIL b2b_old_colour got=%h want=1763", pix); end
    pal_m[1] = v1;
    wr_idx = 4'd2; wr_rgb = v2[11:0]; e = exp_pix(1, 1);
    tick();
    n_tests++;
    if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got=%b want=0", wr_ack); end
    n_tests++;
    if (pix !== e) begin n_fail++; $display("FAIL b2b_new_colour got=%h want=%h", pix, e); end
    index = 4'd2; e = exp_pix(1, 2);
    tick();
    n_tests++;
    if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack2 got=%b want=1", wr_ack); end
    n_tests++;
    if (pix !== e) begin n_fail++; $display("FAIL b2b_old2 got=%h want=%h", pix, e); end
    pal_m[2] = v2;
    wr_req = 1'b0; pix_valid = 1'b0; vblank = 1'b0;
    tick();
    // Random writes under random vblank; an ack is due exactly when vblank was high.
    for (int w = 0; w < 8; w++) begin
      idx = $urandom_range(0, 15); val = $urandom_range(0, 4095); got = 0;
      wr_req = 1'b1; wr_idx = idx[3:0]; wr_rgb = val[11:0];
      for (int c = 0; c < 100 && got == 0; c++) begin
        vb = $urandom_range(0, 1); vblank = vb[0];
        tick();
        n_tests++;
        if (wr_ack !== vb[0]) begin n_fail++; $display("FAIL rand_wr_ack got=%b want=%0d", wr_ack, vb); end
        if (wr_ack === 1'b1) got = 1;
      end
      if (got == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rand_wr_timeout got=no ack want=ack");
      end
      pal_m[idx] = val;
      wr_req = 1'b0; vblank = 1'b0;
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      idx = $urandom_range(0, 15);
      pix_valid = 1'b1; index = idx[3:0]; e = exp_pix(1, idx);
      tick();
      n_tests++;
      if (pix !== e) begin n_fail++; $display("FAIL rand_wr_read idx=%0d got=%h want=%h", idx, pix, e); end
    end
    pix_valid = 1'b0;
    tick();
  endtask

  // Runs `steps` level steps in direction dir, checking level, busy and a lookup after each.
  task automatic run_fade(input int dir, input int steps, input string tag);
    int idx;
    logic [12:0] e;
    done_seen = 0;
    fade_dir = dir[0]; fade_start = 1'b1;
    tick();
    fade_start = 1'b0;
    n_tests++;
    if (fade_busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_start got=%b want=1", tag, fade_busy); end
    for (int s = 1; s <= steps; s++) begin
      for (int f = 0; f < STEP_FRAMES; f++) frame_pulse();
      level_m = (dir != 0) ? level_m + 1 : level_m - 1;
      n_tests++;
      if (level !== 5'(level_m)) begin
        n_fail++; $display("FAIL %s_level step=%0d got=%0d want=%0d", tag, s, level, level_m);
      end
      idx = (s == 1) ? 15 : $urandom_range(0, 15);
      pix_valid = 1'b1; index = idx[3:0]; e = exp_pix(1, idx);
      tick();
      pix_valid = 1'b0;
      n_tests++;
      if (pix !== e) begin n_fail++; $display("FAIL %s_pix step=%0d got=%h want=%h", tag, s, pix, e); end
      if (s == 5) begin
        fade_dir = ~dir[0]; fade_start = 1'b1;
        tick();
        fade_start = 1'b0; fade_dir = dir[0];
      end
    end
  endtask

  task automatic test_fade_out();
    run_fade(0, 16, "fade_out");
    n_tests++;
    if (done_seen != 1) begin n_fail++; $display("FAIL fade_out_done got=%0d pulses want=1", done_seen); end
    n_tests++;
    if (fade_busy !== 1'b0) begin n_fail++; $display("FAIL fade_out_idle got=%b want=0", fade_busy); end
  endtask

  task automatic test_fade_in();
    run_fade(1, 16, "fade_in");
    n_tests++;
    if (done_seen != 1) begin n_fail++; $display("FAIL fade_in_done got=%0d pulses want=1", done_seen); end
    fade_dir = 1'b1; fade_start = 1'b1;
    tick();
    fade_start = 1'b0;
    n_tests++;
    if ({fade_done, fade_busy} !== 2'b10) begin
      n_fail++; $display("FAIL at_target_done got=%b%b want=10", fade_done, fade_busy);
    end
    tick();
    n_tests++;
    if ({fade_done, fade_busy, level} !== {2'b00, 5'd16}) begin
      n_fail++; $display("FAIL at_target_after got=%b%b/%0d want=00/16", fade_done, fade_busy, level);
    end
  endtask

  task automatic test_reset_mid_fade();
    int idx_list [3] = '{7, 0, 14};
    int val;
    for (int w = 0; w < 3; w++) begin
      val = $urandom_range(0, 4095);
      vblank = 1'b1; wr_req = 1'b1; wr_idx = 4'(idx_list[w]); wr_rgb = val[11:0];
      tick();
      wr_req = 1'b0;
      pal_m[idx_list[w]] = val;
      tick();
    end
    vblank = 1'b0;
    run_fade(0, 7, "pre_reset");
    Reset = 1'b1; wr_req = 1'b1; wr_idx = 4'd5; vblank = 1'b1; pix_valid = 1'b1;
    done_seen = 0;
    tick();
    n_tests++;
    if ({wr_ack, fade_done, fade_busy, level} !== {3'b000, 5'd16}) begin
      n_fail++;
      $display("FAIL mid_reset_state got=%b%b%b/%0d want=000/16", wr_ack, fade_done, fade_busy, level);
    end
    n_tests++;
    if (pix !== 13'd0) begin n_fail++; $display("FAIL mid_reset_pix got=%h want=0", pix); end
    Reset = 1'b0; wr_req = 1'b0; vblank = 1'b0; pix_valid = 1'b0;
    foreach (pal_m[i]) pal_m[i] = pal_def[i];
    level_m = 16;
    for (int f = 0; f < 4; f++) frame_pulse();
    n_tests++;
    if ({level, done_seen[0], wr_ack} !== {5'd16, 2'b00}) begin
      n_fail++; $display("FAIL post_reset_idle got=%0d/%0d/%b want=16/0/0", level, done_seen, wr_ack);
    end
    pix_valid = 1'b1; index = 4'd7;
    tick();
    pix_valid = 1'b0;
    n_tests++;
    if (pix !== 13'h1D10) begin n_fail++; $display("FAIL post_reset_default got=%h want=1d10", pix); end
  endtask

  initial begin
    test_reset();
    test_lookup();
    test_write_stall();
    test_back_to_back();
    test_fade_out();
    test_fade_in();
    test_reset_mid_fade();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
